// File: rtl/fpdiv_result_stage.sv
// Registered result stage behind the combinational f32 divider: IEEE special-case
// overrides, per-result and sticky flags, and a 2-entry skid buffer on valid/ready.
module fpdiv_result_stage #(
    parameter logic [31:0] QNAN = 32'h7FC0_0000,
    parameter bit          DAZ  = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [31:0] quotient_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  out_flags,
    output logic        sticky_nv,
    output logic        sticky_dz,
    input  logic        flag_clear
);
    logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sgn;
    logic [31:0] res_c;
    logic [2:0]  flg_c;

    always_comb begin
        a_nan  = (dividend[30:23] == 8'hFF) && (dividend[22:0] != '0);
        a_inf  = (dividend[30:23] == 8'hFF) && (dividend[22:0] == '0);
        a_zero = (dividend[30:23] == 8'h00) && (DAZ || (dividend[22:0] == '0));
        b_nan  = (divisor[30:23] == 8'hFF) && (divisor[22:0] != '0);
        b_inf  = (divisor[30:23] == 8'hFF) && (divisor[22:0] == '0);
        b_zero = (divisor[30:23] == 8'h00) && (DAZ || (divisor[22:0] == '0));
        sgn    = dividend[31] ^ divisor[31];
        res_c  = quotient_in;
        flg_c  = 3'b000;
        // Flags are {NV, DZ, SPC}; the if-chain order is the override priority.
        if (a_nan || b_nan) begin
            res_c = QNAN;                 flg_c = 3'b001;
        end else if (a_zero && b_zero) begin
            res_c = QNAN;                 flg_c = 3'b101;
        end else if (a_inf && b_inf) begin
            res_c = QNAN;                 flg_c = 3'b101;
        end else if (a_inf) begin
            res_c = {sgn, 8'hFF, 23'h0};  flg_c = 3'b001;
        end else if (b_zero) begin
            res_c = {sgn, 8'hFF, 23'h0};  flg_c = 3'b011;
        end else if (b_inf || a_zero) begin
            res_c = {sgn, 8'h00, 23'h0};  flg_c = 3'b001;
        end
    end

    logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [31:0] out_res_q, out_res_d, skid_res_q, skid_res_d;
    logic [2:0]  out_flg_q, out_flg_d, skid_flg_q, skid_flg_d;
    logic        sticky_nv_q, sticky_nv_d, sticky_dz_q, sticky_dz_d;
    logic        out_leave, accept;

    // in_ready depends only on SKID occupancy, so out_ready never reaches it combinationally.
    assign in_ready  = !skid_valid_q;
    assign out_leave = out_valid_q && out_ready;
    assign accept    = in_valid && in_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_res_d    = out_res_q;
        out_flg_d    = out_flg_q;
        skid_valid_d = skid_valid_q;
        skid_res_d   = skid_res_q;
        skid_flg_d   = skid_flg_q;
        if (skid_valid_q) begin
            if (out_leave) begin
                out_res_d    = skid_res_q;
                out_flg_d    = skid_flg_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || out_leave) begin
                out_valid_d = 1'b1;
                out_res_d   = res_c;
                out_flg_d   = flg_c;
            end else begin
                skid_valid_d = 1'b1;
                skid_res_d   = res_c;
                skid_flg_d   = flg_c;
            end
        end else if (out_leave) begin
            out_valid_d = 1'b0;
        end
        // A flag raised by this cycle's transfer survives a simultaneous clear.
        sticky_nv_d = (flag_clear ? 1'b0 : sticky_nv_q) | (out_leave & out_flg_q[2]);
        sticky_dz_d = (flag_clear ? 1'b0 : sticky_dz_q) | (out_leave & out_flg_q[1]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_res_q    <= '0;
            out_flg_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_res_q   <= '0;
            skid_flg_q   <= '0;
            sticky_nv_q  <= 1'b0;
            sticky_dz_q  <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_res_q    <= out_res_d;
            out_flg_q    <= out_flg_d;
            skid_valid_q <= skid_valid_d;
            skid_res_q   <= skid_res_d;
            skid_flg_q   <= skid_flg_d;
            sticky_nv_q  <= sticky_nv_d;
            sticky_dz_q  <= sticky_dz_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = out_res_q;
    assign out_flags = out_flg_q;
    assign sticky_nv = sticky_nv_q;
    assign sticky_dz = sticky_dz_q;
endmodule
